// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one step per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle
// product (IDLE -> FIX); divides are unchanged. Results are identical in both builds.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_q, neg_d;      // product / quotient negative
    logic                   rneg_q, rneg_d;    // remainder negative (sign of dividend)
    logic                   zero_q, zero_d;    // divide with zero divisor
    logic [WIDTH-1:0]       b_q, b_d;          // multiplicand or divisor magnitude
    logic [WIDTH-1:0]       orig_a_q, orig_a_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;      // {upper, lower}: product or {rem, quot}
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                   done_q, done_d, dbz_q, dbz_d;

    logic                   sign_a, sign_b;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH+1:0]       div_diff;
    logic [2*WIDTH-1:0]     step_acc, prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    // Operand magnitudes and one iteration step of either algorithm.
    always_comb begin
        sign_a    = ~op[0] & operand_a[WIDTH-1];
        sign_b    = ~op[0] & operand_b[WIDTH-1];
        a_mag     = sign_a ? -operand_a : operand_a;
        b_mag     = sign_b ? -operand_b : operand_b;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Remainder shifted left with next dividend bit; needs WIDTH+1 bits.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state, datapath load/step and HI/LO write selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        zero_d   = zero_q;
        b_d      = b_q;
        orig_a_d = orig_a_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = sign_a ^ sign_b;
                    rneg_d   = sign_a;
                    zero_d   = op[1] & (operand_b == '0);
                    b_d      = b_mag;
                    orig_a_d = operand_a;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    cnt_d    = CntW'(WIDTH - 1);
                    state_d  = StRun;
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        state_d = StFix;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            StRun: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (zero_q) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                dbz_d   = is_div_q & zero_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            b_q      <= '0;
            orig_a_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            zero_q   <= zero_d;
            b_q      <= b_d;
            orig_a_q <= orig_a_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
